// File: rtl/oclib_xxtea_encrypt.sv
// oclib_xxtea_encrypt: iterative XXTEA encryption of one 2-word (64-bit) block under a 128-bit key.
// Build option: define OC_XXTEA_ENCRYPT_UNROLL2_EN to update both words per RUN cycle
// (latency Rounds instead of 2*Rounds); ciphertext is identical in both builds.
module oclib_xxtea_encrypt #(
    parameter int unsigned Rounds = 32,
    parameter logic [31:0] Delta  = 32'h9e3779b9
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [1:0][31:0] in,
    input  logic [127:0]     key,
    output logic             outValid,
    input  logic             outReady,
    output logic [1:0][31:0] out,
    output logic             busy
);

    localparam int unsigned CntW = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0][31:0] v;
    logic [1:0][31:0] v_upd_c;
    logic [3:0][31:0] k_reg;
    logic [31:0]      sum;
    logic [CntW-1:0]  round_cnt;
    logic             accept_c;
    logic             round_end_c;
    logic             last_c;

    // XXTEA mixing function; for a 2-word block y and z always name the same word
    function automatic logic [31:0] mx_f(input logic [31:0] y, input logic [31:0] z,
                                         input logic [31:0] s, input logic [31:0] kk);
        return (((z >> 5) ^ (y << 2)) + ((y >> 3) ^ (z << 4))) ^ ((s ^ y) + (kk ^ z));
    endfunction

    assign accept_c = inValid && inReady;
    assign last_c   = round_end_c && (round_cnt == '0);
    assign out      = v;

`ifdef OC_XXTEA_ENCRYPT_UNROLL2_EN
    logic [31:0] w0_c;

    // Both word updates chained in one cycle; the second uses the freshly updated v[0]
    always_comb begin
        w0_c        = v[0] + mx_f(v[1], v[1], sum, k_reg[sum[3:2]]);
        v_upd_c[0]  = w0_c;
        v_upd_c[1]  = v[1] + mx_f(w0_c, w0_c, sum, k_reg[2'd1 ^ sum[3:2]]);
        round_end_c = 1'b1;
    end
`else
    logic        p;
    logic [31:0] yz_c;

    // One word update per cycle; the neighbour word v[~p] serves as both y and z
    always_comb begin
        yz_c        = v[~p];
        v_upd_c     = v;
        v_upd_c[p]  = v[p] + mx_f(yz_c, yz_c, sum, k_reg[{1'b0, p} ^ sum[3:2]]);
        round_end_c = p;
    end

    // Word pointer alternates 0,1 through each round
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            p <= 1'b0;
        end else if (accept_c) begin
            p <= 1'b0;
        end else if (state == RUN) begin
            p <= ~p;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = RUN;
            RUN:     if (last_c)   state_next = DONE;
            DONE:    if (outReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and handshake outputs, registered from the next state
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            inReady  <= 1'b0;
            outValid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            inReady  <= (state_next == IDLE);
            outValid <= (state_next == DONE);
            busy     <= (state_next != IDLE);
        end
    end

    // Block datapath: capture at accept, iterate in RUN, hold otherwise
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            v         <= '0;
            k_reg     <= '0;
            sum       <= '0;
            round_cnt <= '0;
        end else if (accept_c) begin
            v         <= in;
            k_reg     <= key;
            sum       <= Delta;
            round_cnt <= CntW'(Rounds - 1);
        end else if (state == RUN) begin
            v <= v_upd_c;
            if (round_end_c && !last_c) begin
                sum       <= sum + Delta;
                round_cnt <= round_cnt - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_oclib_xxtea_encrypt.sv
// tb_oclib_xxtea_encrypt: scoreboard bench for the XXTEA encrypt engine.
module tb_oclib_xxtea_encrypt;

    localparam int unsigned ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9e3779b9;
`ifdef OC_XXTEA_ENCRYPT_UNROLL2_EN
    localparam int unsigned LAT = ROUNDS;
`else
    localparam int unsigned LAT = 2 * ROUNDS;
`endif
    localparam logic [63:0] KAT_CT = 64'h575d8c80_053704ab;

    logic             clock    = 1'b0;
    logic             resetN   = 1'b1;
    logic             inValid  = 1'b0;
    logic             outReady = 1'b0;
    logic             inReady;
    logic             outValid;
    logic             busy;
    logic [1:0][31:0] din      = '0;
    logic [1:0][31:0] dout;
    logic [127:0]     dkey     = '0;

    int          n_cmp     = 0;
    int          n_err     = 0;
    int          cyc       = 0;
    int          acc_cycle = 0;
    int          acc_t [4];
    logic        ov_q      = 1'b0;
    logic [63:0] sb [$];
    logic [63:0] exp_v;
    logic [63:0] d;
    logic [63:0] snap;
    logic [127:0] k;
    int          t;
    int          bad;

    oclib_xxtea_encrypt #(.Rounds(ROUNDS), .Delta(DELTA)) dut (
        .clock    (clock),
        .resetN   (resetN),
        .inValid  (inValid),
        .inReady  (inReady),
        .in       (din),
        .key      (dkey),
        .outValid (outValid),
        .outReady (outReady),
        .out      (dout),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] kw(input logic [127:0] kk, input int i);
        return kk[32*i +: 32];
    endfunction

    function automatic logic [31:0] mxf(input logic [31:0] y, input logic [31:0] z,
                                        input logic [31:0] s, input logic [31:0] kk);
        return (((z >> 5) ^ (y << 2)) + ((y >> 3) ^ (z << 4))) ^ ((s ^ y) + (kk ^ z));
    endfunction

    // Reference XXTEA encryption, n = 2
    function automatic logic [63:0] enc(input logic [63:0] pt, input logic [127:0] kk);
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] s;
        v0 = pt[31:0];
        v1 = pt[63:32];
        s  = '0;
        for (int r = 0; r < int'(ROUNDS); r++) begin
            s  = s + DELTA;
            v0 = v0 + mxf(v1, v1, s, kw(kk, int'(s[3:2])));
            v1 = v1 + mxf(v0, v0, s, kw(kk, int'(s[3:2]) ^ 1));
        end
        return {v1, v0};
    endfunction

    // Reference XXTEA decryption, n = 2
    function automatic logic [63:0] dec(input logic [63:0] ct, input logic [127:0] kk);
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] s;
        v0 = ct[31:0];
        v1 = ct[63:32];
        s  = 32'(ROUNDS) * DELTA;
        for (int r = 0; r < int'(ROUNDS); r++) begin
            v1 = v1 - mxf(v0, v0, s, kw(kk, int'(s[3:2]) ^ 1));
            v0 = v0 - mxf(v1, v1, s, kw(kk, int'(s[3:2])));
            s  = s - DELTA;
        end
        return {v1, v0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [63:0] pt, input logic [127:0] kk, input logic [63:0] ct);
        int w = 0;
        din     = pt;
        dkey    = kk;
        inValid = 1'b1;
        while (!inReady && w < 400) begin
            tick();
            w++;
        end
        chk("accept_wait", 128'(inReady), 128'(1));
        tick();
        acc_cycle = cyc;
        sb.push_back(ct);
        inValid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 500) begin
            tick();
            w++;
        end
        chk("drain", 128'(sb.size()), 128'(0));
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!outValid && w < 500) begin
            tick();
            w++;
        end
        chk("valid_wait", 128'(outValid), 128'(1));
    endtask

    // Output monitor: latency on outValid rise, ciphertext on each handshake
    always @(negedge clock) begin
        if (!resetN) begin
            ov_q = 1'b0;
        end else begin
            if (outValid && !ov_q) chk("latency", 128'(cyc - acc_cycle), 128'(LAT));
            ov_q = outValid;
            if (outValid && outReady) begin
                chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    exp_v = sb.pop_front();
                    chk("ciphertext", 128'(dout), 128'(exp_v));
                end
            end
        end
    end

    initial begin
        // Reset
        #1 resetN = 1'b0;
        #2 chk("rst_outputs", 128'({inReady, outValid, busy, dout}), 128'(0));
        tick();
        tick();
        resetN = 1'b1;
        tick();
        chk("idle_after_rst", 128'({inReady, outValid, busy}), 128'(3'b100));

        // Known answer
        outReady = 1'b1;
        send(64'h0, 128'h0, KAT_CT);
        drain();

        // Round trip through the reference decryptor
        k = 128'h44444444_33333333_22222222_11111111;
        d = {32'h89abcdef, 32'h12345678};
        send(d, k, enc(d, k));
        wait_valid();
        chk("roundtrip", 128'(dec(64'(dout), k)), 128'(d));
        drain();

        // Backpressure with a second block offered while DONE
        outReady = 1'b0;
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(d, k, enc(d, k));
        wait_valid();
        snap    = 64'(dout);
        din     = ~d;
        inValid = 1'b1;
        repeat (20) begin
            tick();
            chk("bp_hold", 128'({64'(dout), outValid, inReady}), 128'({snap, 1'b1, 1'b0}));
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        inValid  = 1'b0;
        chk("bp_release", 128'({inReady, outValid, busy}), 128'(3'b100));
        repeat (3) tick();
        chk("bp_no_second", 128'({busy, sb.size() == 0}), 128'(2'b01));

        // Input isolation: in/key scrambled every cycle during RUN
        outReady = 1'b1;
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(d, k, enc(d, k));
        t = 0;
        while (!outValid && t < 500) begin
            din  = {$urandom, $urandom};
            dkey = {$urandom, $urandom, $urandom, $urandom};
            tick();
            t++;
        end
        drain();

        // Reset in the middle of RUN
        send(64'h0, 128'h0, KAT_CT);
        repeat (30) tick();
        resetN = 1'b0;
        sb.delete();
        #1 chk("rst_mid", 128'({outValid, busy, inReady, dout}), 128'(0));
        tick();
        tick();
        resetN = 1'b1;
        bad = 0;
        repeat (2 * LAT + 10) begin
            tick();
            if (outValid || busy) bad++;
        end
        chk("rst_no_valid", 128'(bad), 128'(0));
        send(64'h0, 128'h0, KAT_CT);
        drain();

        // Streaming with valid/ready held high
        outReady = 1'b1;
        inValid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d    = {$urandom, $urandom};
            k    = {$urandom, $urandom, $urandom, $urandom};
            din  = d;
            dkey = k;
            t    = 0;
            while (!inReady && t < 400) begin
                tick();
                t++;
            end
            chk("stream_accept_wait", 128'(inReady), 128'(1));
            tick();
            acc_cycle = cyc;
            acc_t[i]  = cyc;
            sb.push_back(enc(d, k));
        end
        inValid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("stream_spacing", 128'(acc_t[i] - acc_t[i-1]), 128'(LAT + 2));
        end
        drain();

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
